// File: rtl/mul_share_arb_if.sv
// Bundle of the requester, multiplier and response signals around mul_share_arb.
//   slave  : arbiter view (takes requests, drives the multiplier, returns responses)
//   master : environment view (requesters, multiplier and response consumer)
// Requester r owns req_valid[r], req_ready[r] and operand bytes req_a/req_b[8r+7:8r].
interface mul_share_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              mul_start;
  logic [7:0]        mul_a;
  logic [7:0]        mul_b;
  logic              mul_done;
  logic [7:0]        mul_p;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_data;
  logic              rsp_err;
  logic              busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_done, mul_p, rsp_ready,
    output req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_done, mul_p, rsp_ready,
    input  req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/mul_share_arb.sv
// Round-robin arbiter/sequencer sharing one multi-cycle 8x8 multiplier among
// NREQ requesters. One operand pair is accepted per transaction, issued with a
// one-cycle start pulse, and the mod-256 product (or a timeout abort) is
// returned tagged with the requester index.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mul_share_arb_if.slave (requests, multiplier handshake, response, busy)
//
// state | meaning
// IDLE  | arbitrating; req_ready one-hot to the round-robin winner
// ISSUE | mul_start pulse, wait counter cleared
// WAIT  | waiting for mul_done or timeout
// RESP  | response held until rsp_ready
module mul_share_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16,
  parameter int IDW     = 2
) (
  input logic            clk,
  input logic            rst_n,
  mul_share_arb_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, stateNxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  cand;
  logic            anyValid;
  logic            accept;
  logic            bypass;
  logic            timeoutHit;
  logic [CW-1:0]   waitCnt;
  logic [7:0]      aArr [NREQ];
  logic [7:0]      bArr [NREQ];
  logic [7:0]      winA, winB;
  logic [7:0]      aReg, bReg, dataReg;
  logic [IDW-1:0]  idReg;
  logic            errReg;
  logic [NREQ-1:0] grant;

  always_comb begin
    for (int j = 0; j < NREQ; j++) begin
      aArr[j] = bus.req_a[8*j +: 8];
      bArr[j] = bus.req_b[8*j +: 8];
    end
  end

  // Search upward from ptr+1; the last winner ends up lowest priority.
  always_comb begin
    winner   = '0;
    cand     = '0;
    anyValid = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(ptr) + i) % NREQ);
      if (!anyValid && bus.req_valid[cand]) begin
        anyValid = 1'b1;
        winner   = cand;
      end
    end
  end

  assign winA       = aArr[winner];
  assign winB       = bArr[winner];
  assign accept     = (state == IDLE) && anyValid;
  assign bypass     = (winA == 8'd0) || (winB == 8'd0);
  // Counter holds k in the k-th WAIT cycle, so the last allowed cycle is TIMEOUT-1.
  assign timeoutHit = (waitCnt == CW'(TIMEOUT - 1));

  always_comb begin
    grant = '0;
    for (int j = 0; j < NREQ; j++) begin
      grant[j] = accept && (winner == IDW'(j));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:  if (accept) stateNxt = bypass ? RESP : ISSUE;
      ISSUE: stateNxt = WAIT;
      WAIT:  if (bus.mul_done || timeoutHit) stateNxt = RESP;
      RESP:  if (bus.rsp_ready) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= IDW'(NREQ - 1);
      aReg    <= '0;
      bReg    <= '0;
      idReg   <= '0;
      dataReg <= '0;
      errReg  <= 1'b0;
      waitCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ptr     <= winner;
            aReg    <= winA;
            bReg    <= winB;
            idReg   <= winner;
            dataReg <= '0;
            errReg  <= 1'b0;
          end
        end
        ISSUE: waitCnt <= '0;
        WAIT: begin
          waitCnt <= waitCnt + CW'(1);
          // done wins over a coincident timeout
          if (bus.mul_done) begin
            dataReg <= bus.mul_p;
            errReg  <= 1'b0;
          end else if (timeoutHit) begin
            dataReg <= '0;
            errReg  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.mul_start = (state == ISSUE);
  assign bus.mul_a     = aReg;
  assign bus.mul_b     = bReg;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = idReg;
  assign bus.rsp_data  = dataReg;
  assign bus.rsp_err   = errReg;
  assign bus.busy      = (state != IDLE);
endmodule
